// File: rtl/disp_pkg.sv
// Shared constants for the two-digit 7-segment scan path: digit-enable codes,
// active-low segment patterns {dp,g,f,e,d,c,b,a} and the scan slot encoding.
package disp_pkg;

    localparam logic [1:0] COL_TENS  = 2'b10;
    localparam logic [1:0] COL_UNITS = 2'b01;
    localparam logic [1:0] COL_OFF   = 2'b11;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    // Slot 0 drives the tens digit, slot 1 the units digit.
    typedef enum logic {
        SLOT_TENS  = 1'b0,
        SLOT_UNITS = 1'b1
    } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; dp always off.
// Non-decimal nibbles show a dash so a corrupt code is visible, not random.
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    // Segment lookup
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_scan_scheduler.sv
// Two-digit display scan scheduler. A slot counter alternates tens/units,
// each slot opening with a blank window against ghosting. At every frame
// boundary the display is granted to B (priority) or A and their BCD value is
// snapshotted, so a frame never mixes two sources. Outputs are registered from
// the next-state values so pins move on the same edge as the counter.
module digit_scan_scheduler
    import disp_pkg::*;
#(
    parameter logic [18:0] T_SCAN       = 19'd499_999,
    parameter logic [18:0] T_BLANK      = 19'd2_499,
    parameter logic [5:0]  BLINK_FRAMES = 6'd49
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Req_A,
    input  logic [7:0] Data_A,
    input  logic       Req_B,
    input  logic [7:0] Data_B,
    input  logic       Blink_En,
    output logic       Grant_A,
    output logic       Grant_B,
    output logic       Frame_Done,
    output logic [1:0] Column_Scan_Sig,
    output logic [7:0] Row_Scan_Sig
);

    logic [18:0] r_count;
    slot_e       r_slot;
    logic        r_grant_a, r_grant_b;
    logic [7:0]  r_snap;
    logic        r_phase;
    logic [5:0]  r_blink_cnt;
    logic        r_frame_done;
    logic [1:0]  r_col;
    logic [7:0]  r_row;

    logic        w_wrap, w_bound;
    logic [18:0] w_count_nx;
    slot_e       w_slot_nx;
    logic        w_grant_a_nx, w_grant_b_nx;
    logic [7:0]  w_snap_nx;
    logic        w_phase_nx;
    logic [5:0]  w_blink_cnt_nx;
    logic [3:0]  w_nibble;
    logic [7:0]  w_seg;
    logic        w_show;
    logic [1:0]  w_col_nx;
    logic [7:0]  w_row_nx;
    logic        w_frame_done_nx;

    // Scan counter: count within a slot, toggle slot on wrap
    always_comb begin
        w_wrap     = (r_count == T_SCAN);
        w_bound    = w_wrap && (r_slot == SLOT_UNITS);
        w_count_nx = w_wrap ? 19'd0 : r_count + 19'd1;
        w_slot_nx  = r_slot;
        if (w_wrap)
            w_slot_nx = (r_slot == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
    end

    // Frame-aligned arbitration: B wins, A otherwise, else nobody
    always_comb begin
        w_grant_a_nx = r_grant_a;
        w_grant_b_nx = r_grant_b;
        w_snap_nx    = r_snap;
        if (w_bound) begin
            w_grant_b_nx = Req_B;
            w_grant_a_nx = Req_A && !Req_B;
            if (Req_B)
                w_snap_nx = Data_B;
            else if (Req_A)
                w_snap_nx = Data_A;
        end
    end

    // Blink phase: advances only at frame boundaries, forced ON when disabled
    always_comb begin
        w_phase_nx     = r_phase;
        w_blink_cnt_nx = r_blink_cnt;
        if (w_bound) begin
            if (!Blink_En) begin
                w_phase_nx     = 1'b1;
                w_blink_cnt_nx = 6'd0;
            end else if (r_blink_cnt == BLINK_FRAMES) begin
                w_phase_nx     = !r_phase;
                w_blink_cnt_nx = 6'd0;
            end else begin
                w_blink_cnt_nx = r_blink_cnt + 6'd1;
            end
        end
    end

    assign w_nibble = (w_slot_nx == SLOT_UNITS) ? w_snap_nx[3:0] : w_snap_nx[7:4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_seg)
    );

    // Pin decode from next-state so outputs carry no extra latency
    always_comb begin
        w_show          = (w_grant_a_nx || w_grant_b_nx) && w_phase_nx &&
                          (w_count_nx > T_BLANK);
        w_col_nx        = COL_OFF;
        w_row_nx        = SEG_OFF;
        if (w_show) begin
            w_col_nx = (w_slot_nx == SLOT_UNITS) ? COL_UNITS : COL_TENS;
            w_row_nx = w_seg;
        end
        w_frame_done_nx = (w_slot_nx == SLOT_UNITS) && (w_count_nx == T_SCAN);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_count      <= 19'd0;
            r_slot       <= SLOT_TENS;
            r_grant_a    <= 1'b0;
            r_grant_b    <= 1'b0;
            r_snap       <= 8'h00;
            r_phase      <= 1'b1;
            r_blink_cnt  <= 6'd0;
            r_frame_done <= 1'b0;
            r_col        <= COL_OFF;
            r_row        <= SEG_OFF;
        end else begin
            r_count      <= w_count_nx;
            r_slot       <= w_slot_nx;
            r_grant_a    <= w_grant_a_nx;
            r_grant_b    <= w_grant_b_nx;
            r_snap       <= w_snap_nx;
            r_phase      <= w_phase_nx;
            r_blink_cnt  <= w_blink_cnt_nx;
            r_frame_done <= w_frame_done_nx;
            r_col        <= w_col_nx;
            r_row        <= w_row_nx;
        end
    end

    assign Grant_A         = r_grant_a;
    assign Grant_B         = r_grant_b;
    assign Frame_Done      = r_frame_done;
    assign Column_Scan_Sig = r_col;
    assign Row_Scan_Sig    = r_row;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Directed bench for digit_scan_scheduler with a 20-cycle frame
// (T_SCAN=9, T_BLANK=1, BLINK_FRAMES=2). Outputs are sampled on the falling
// edge; cycle c of a frame is the c-th falling edge after the boundary.
module tb_digit_scan_scheduler;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Req_A, Req_B, Blink_En;
    logic [7:0] Data_A, Data_B;
    logic       Grant_A, Grant_B, Frame_Done;
    logic [1:0] Column_Scan_Sig;
    logic [7:0] Row_Scan_Sig;

    int total = 0;
    int bad   = 0;

    // Pending mid-frame input change, applied at falling edge of cycle stg_c
    int         stg_c = -1;
    logic       stg_req_a, stg_req_b, stg_blink;
    logic [7:0] stg_da, stg_db;

    logic [12:0] got, exp;

    digit_scan_scheduler #(
        .T_SCAN       (19'd9),
        .T_BLANK      (19'd1),
        .BLINK_FRAMES (6'd2)
    ) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .Req_A           (Req_A),
        .Data_A          (Data_A),
        .Req_B           (Req_B),
        .Data_B          (Data_B),
        .Blink_En        (Blink_En),
        .Grant_A         (Grant_A),
        .Grant_B         (Grant_B),
        .Frame_Done      (Frame_Done),
        .Column_Scan_Sig (Column_Scan_Sig),
        .Row_Scan_Sig    (Row_Scan_Sig)
    );

    always #5 CLK = ~CLK;

    // Expected {Grant_A,Grant_B,Frame_Done,Column,Row} at frame cycle c
    function automatic logic [12:0] exp_vec(input int c, input logic vis,
                                            input logic ga, input logic gb,
                                            input logic [7:0] tr, input logic [7:0] ur);
        logic [1:0] col;
        logic [7:0] row;
        col = 2'b11;
        row = 8'hFF;
        if (vis && c >= 2 && c <= 9) begin
            col = 2'b10;
            row = tr;
        end else if (vis && c >= 12) begin
            col = 2'b01;
            row = ur;
        end
        return {ga, gb, (c == 19), col, row};
    endfunction

    task automatic set_stage(input int c);
        stg_c     = c;
        stg_req_a = Req_A;
        stg_req_b = Req_B;
        stg_blink = Blink_En;
        stg_da    = Data_A;
        stg_db    = Data_B;
    endtask

    task automatic tick(input int c);
        @(negedge CLK);
        got = {Grant_A, Grant_B, Frame_Done, Column_Scan_Sig, Row_Scan_Sig};
        if (c == stg_c) begin
            Req_A    = stg_req_a;
            Req_B    = stg_req_b;
            Blink_En = stg_blink;
            Data_A   = stg_da;
            Data_B   = stg_db;
            stg_c    = -1;
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0; Req_A = 1'b1; Data_A = 8'h42; Req_B = 1'b0; Data_B = 8'h00;
        Blink_En = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        got = {Grant_A, Grant_B, Frame_Done, Column_Scan_Sig, Row_Scan_Sig};
        if (got !== 13'h03FF) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", got, 13'h03FF);
        end
        @(posedge CLK); #1 RSTn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF); total++;
            if (got !== exp) begin bad++; $display("FAIL reset_first_frame c=%0d got=%h exp=%h", c, got, exp); end
        end
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'h99, 8'hA4); total++;
            if (got !== exp) begin bad++; $display("FAIL grant_a_42 c=%0d got=%h exp=%h", c, got, exp); end
        end
    endtask

    task automatic test_priority();
        set_stage(10); stg_req_b = 1'b1; stg_db = 8'hE1;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'h99, 8'hA4); total++;
            if (got !== exp) begin bad++; $display("FAIL prio_hold_a c=%0d got=%h exp=%h", c, got, exp); end
        end
        set_stage(5); stg_req_b = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b0, 1'b1, 8'hBF, 8'hF9); total++;
            if (got !== exp) begin bad++; $display("FAIL prio_grant_b c=%0d got=%h exp=%h", c, got, exp); end
        end
    endtask

    task automatic test_data_change();
        set_stage(10); stg_da = 8'h37;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'h99, 8'hA4); total++;
            if (got !== exp) begin bad++; $display("FAIL data_no_tear c=%0d got=%h exp=%h", c, got, exp); end
        end
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'hB0, 8'hF8); total++;
            if (got !== exp) begin bad++; $display("FAIL data_37 c=%0d got=%h exp=%h", c, got, exp); end
        end
    endtask

    task automatic test_idle();
        set_stage(7); stg_req_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'hB0, 8'hF8); total++;
            if (got !== exp) begin bad++; $display("FAIL idle_last_a c=%0d got=%h exp=%h", c, got, exp); end
        end
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 20; c++) begin
                tick(c); exp = exp_vec(c, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF); total++;
                if (got !== exp) begin bad++; $display("FAIL idle_blank f=%0d c=%0d got=%h exp=%h", f, c, got, exp); end
            end
        end
    endtask

    task automatic test_blink();
        // Frame visibility with blink enabled during frame 0, disabled in frame 9
        logic vis_tbl [11];
        vis_tbl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        Req_A = 1'b1;
        for (int f = 0; f < 11; f++) begin
            if (f == 0) begin set_stage(10); stg_blink = 1'b1; end
            if (f == 9) begin set_stage(10); stg_blink = 1'b0; end
            for (int c = 0; c < 20; c++) begin
                tick(c); exp = exp_vec(c, vis_tbl[f], 1'b1, 1'b0, 8'hB0, 8'hF8); total++;
                if (got !== exp) begin bad++; $display("FAIL blink f=%0d c=%0d got=%h exp=%h", f, c, got, exp); end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 16; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'hB0, 8'hF8); total++;
            if (got !== exp) begin bad++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got, exp); end
        end
        #2 RSTn = 1'b0;
        #1 got = {Grant_A, Grant_B, Frame_Done, Column_Scan_Sig, Row_Scan_Sig};
        total++;
        if (got !== 13'h03FF) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, 13'h03FF); end
        @(posedge CLK); #1 got = {Grant_A, Grant_B, Frame_Done, Column_Scan_Sig, Row_Scan_Sig};
        total++;
        if (got !== 13'h03FF) begin bad++; $display("FAIL reset_over_edge got=%h exp=%h", got, 13'h03FF); end
        @(posedge CLK); #1 RSTn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF); total++;
            if (got !== exp) begin bad++; $display("FAIL post_reset_blank c=%0d got=%h exp=%h", c, got, exp); end
        end
        for (int c = 0; c < 20; c++) begin
            tick(c); exp = exp_vec(c, 1'b1, 1'b1, 1'b0, 8'hB0, 8'hF8); total++;
            if (got !== exp) begin bad++; $display("FAIL post_reset_show c=%0d got=%h exp=%h", c, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_data_change();
        test_idle();
        test_blink();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
